// File: rtl/arb_grant_mux.sv
// Steers the granted source's beat into a registered valid/ready output slot and pulses its ack; one-cycle latency.
// Holds the slot under backpressure. Caps beats per grant at MAX_TENURE. Optional beat counter: ARB_GRANT_MUX_STATS_EN.
module arb_grant_mux #(
  parameter int DW         = 8,
  parameter int MAX_TENURE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt3,
  input  logic          gnt2,
  input  logic          gnt1,
  input  logic          gnt0,
  input  logic          vld3,
  input  logic          vld2,
  input  logic          vld1,
  input  logic          vld0,
  input  logic [DW-1:0] data3,
  input  logic [DW-1:0] data2,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data0,
  output logic          ack3,
  output logic          ack2,
  output logic          ack1,
  output logic          ack0,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          tenure_exp,
  output logic          gnt_err,
  output logic [15:0]   beat_cnt
);

  localparam logic [3:0] MAX_T = 4'(MAX_TENURE);

  logic [3:0]    gnt_v;
  logic [3:0]    vld_v;
  logic [3:0]    ack_v;
  logic [3:0]    prev_gnt;
  logic [3:0]    tcnt;
  logic [3:0]    tcnt_nxt;
  logic [1:0]    sel;
  logic          active;
  logic          multi;
  logic          same_gnt;
  logic          load;
  logic [DW-1:0] sel_data;

  assign gnt_v = {gnt3, gnt2, gnt1, gnt0};
  assign vld_v = {vld3, vld2, vld1, vld0};

  always_comb begin
    sel    = 2'd0;
    active = 1'b0;
    case (gnt_v)
      4'b0001: begin sel = 2'd0; active = 1'b1; end
      4'b0010: begin sel = 2'd1; active = 1'b1; end
      4'b0100: begin sel = 2'd2; active = 1'b1; end
      4'b1000: begin sel = 2'd3; active = 1'b1; end
      default: begin sel = 2'd0; active = 1'b0; end
    endcase
  end

  assign multi = (gnt_v != 4'b0000) && !active;

  always_comb begin
    sel_data = data0;
    case (sel)
      2'd0: sel_data = data0;
      2'd1: sel_data = data1;
      2'd2: sel_data = data2;
      2'd3: sel_data = data3;
      default: sel_data = data0;
    endcase
  end

  // Expiry only counts against the grant that used it up, so a new grant loads on its first cycle.
  assign same_gnt   = (gnt_v == prev_gnt);
  assign tenure_exp = same_gnt && (tcnt == MAX_T);

  assign load  = rst && active && vld_v[sel] && (!out_vld || out_rdy) && !tenure_exp;
  assign ack_v = load ? (4'b0001 << sel) : 4'b0000;
  assign {ack3, ack2, ack1, ack0} = ack_v;

  // A changed grant restarts the count, but a beat taken on that first cycle still counts.
  always_comb begin
    tcnt_nxt = (active && same_gnt) ? tcnt : 4'd0;
    if (load && (tcnt_nxt != MAX_T))
      tcnt_nxt = tcnt_nxt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= 2'd0;
      tcnt     <= 4'd0;
      prev_gnt <= 4'd0;
      gnt_err  <= 1'b0;
    end else begin
      tcnt     <= tcnt_nxt;
      prev_gnt <= gnt_v;
      if (multi)
        gnt_err <= 1'b1;
      if (load) begin
        out_data <= sel_data;
        out_src  <= sel;
        out_vld  <= 1'b1;
      end else if (out_rdy) begin
        out_vld  <= 1'b0;
      end
    end
  end

`ifdef ARB_GRANT_MUX_STATS_EN
  logic [15:0] beat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      beat_q <= 16'd0;
    else if (load)
      beat_q <= beat_q + 16'd1;
  end

  assign beat_cnt = beat_q;
`else
  assign beat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_arb_grant_mux.sv
module tb_arb_grant_mux;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          gnt3 = 0, gnt2 = 0, gnt1 = 0, gnt0 = 0;
  logic          vld3 = 0, vld2 = 0, vld1 = 0, vld0 = 0;
  logic [DW-1:0] data3 = 0, data2 = 0, data1 = 0, data0 = 0;
  logic          ack3, ack2, ack1, ack0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic          tenure_exp;
  logic          gnt_err;
  logic [15:0]   beat_cnt;

  logic [3:0]    acks;
  logic [DW+1:0] sb[$];
  int            n_cmp = 0;
  int            n_err = 0;

  assign acks = {ack3, ack2, ack1, ack0};

  arb_grant_mux #(.DW(DW), .MAX_TENURE(4)) dut (
    .clk(clk), .rst(rst),
    .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
    .vld3(vld3), .vld2(vld2), .vld1(vld1), .vld0(vld0),
    .data3(data3), .data2(data2), .data1(data1), .data0(data0),
    .ack3(ack3), .ack2(ack2), .ack1(ack1), .ack0(ack0),
    .out_data(out_data), .out_src(out_src), .out_vld(out_vld), .out_rdy(out_rdy),
    .tenure_exp(tenure_exp), .gnt_err(gnt_err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gnt(input logic [3:0] g);
    {gnt3, gnt2, gnt1, gnt0} = g;
  endtask

  // Scoreboard consumer: a beat leaves the output slot on every edge with out_vld & out_rdy.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", {22'd0, out_src, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [DW+1:0] e;
        e = sb.pop_front();
        chk("sb_data", {24'd0, out_data}, {24'd0, e[DW-1:0]});
        chk("sb_src", {30'd0, out_src}, {30'd0, e[DW+1:DW]});
      end
    end
  end

  initial begin
    int n_ack;
    int n_beats;
    logic [15:0] exp_cnt;
`ifdef ARB_GRANT_MUX_STATS_EN
    n_beats = 70000;
`else
    n_beats = 20;
`endif
    exp_cnt = 16'(n_beats);
`ifndef ARB_GRANT_MUX_STATS_EN
    exp_cnt = 16'd0;
`endif

    // Reset state, with a legal request present: no ack while in reset
    set_gnt(4'b0001); vld0 = 1; data0 = 8'h77;
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_gnt_err", gnt_err, 0);
    chk("rst_tenure_exp", tenure_exp, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_acks", acks, 0);
    set_gnt(4'b0000); vld0 = 0;
    #2 rst = 1;

    // 1: single beat from source 0
    cyc(); set_gnt(4'b0001); vld0 = 1; data0 = 8'hA5; out_rdy = 1;
    @(negedge clk);
    chk("t1_ack", acks, 4'b0001); sb.push_back({2'd0, 8'hA5});
    cyc(); set_gnt(4'b0000); vld0 = 0;
    @(negedge clk);
    chk("t1_out_vld", out_vld, 1);
    chk("t1_out_data", out_data, 8'hA5);
    chk("t1_out_src", out_src, 0);
    chk("t1_ack_idle", acks, 0);
    cyc();
    @(negedge clk);
    chk("t1_drain", out_vld, 0);

    // 2: backpressure then no-bubble replacement
    cyc(); set_gnt(4'b0100); vld2 = 1; data2 = 8'h3C; out_rdy = 0;
    @(negedge clk);
    chk("t2_ack", acks, 4'b0100); sb.push_back({2'd2, 8'h3C});
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      chk("t2_hold_vld", out_vld, 1);
      chk("t2_hold_data", out_data, 8'h3C);
      chk("t2_hold_ack", acks, 0);
    end
    cyc(); out_rdy = 1; data2 = 8'h3D;
    @(negedge clk);
    chk("t2_ack_free", acks, 4'b0100); sb.push_back({2'd2, 8'h3D});
    cyc(); set_gnt(4'b0000); vld2 = 0;
    @(negedge clk);
    chk("t2_nobubble_vld", out_vld, 1);
    chk("t2_nobubble_data", out_data, 8'h3D);
    cyc();

    // 3: tenure limit on gnt1, then switch to gnt3
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); set_gnt(4'b0010); vld1 = 1; data1 = 8'h10 + 8'(i);
      @(negedge clk);
      chk("t3_ack", acks, (i < 4) ? 4'b0010 : 4'b0000);
      chk("t3_tenure_exp", tenure_exp, (i >= 4) ? 1 : 0);
      if (ack1) n_ack++;
      if (i < 4) sb.push_back({2'd1, 8'h10 + 8'(i)});
    end
    chk("t3_ack_count", n_ack, 4);
    cyc(); set_gnt(4'b1000); vld3 = 1; data3 = 8'hC3;
    @(negedge clk);
    chk("t3_switch_exp", tenure_exp, 0);
    chk("t3_switch_ack", acks, 4'b1000); sb.push_back({2'd3, 8'hC3});
    cyc(); set_gnt(4'b0000); vld3 = 0; vld1 = 0;
    @(negedge clk);
    chk("t3_src3", out_src, 3);
    cyc();

    // 4: multi-hot grant
    cyc(); set_gnt(4'b0011); vld0 = 1; vld1 = 1; data0 = 8'h11; data1 = 8'h22;
    @(negedge clk);
    chk("t4_ack_multi", acks, 0);
    chk("t4_err_not_yet", gnt_err, 0);
    cyc(); set_gnt(4'b0001); vld1 = 0;
    @(negedge clk);
    chk("t4_err_set", gnt_err, 1);
    chk("t4_no_vld", out_vld, 0);
    chk("t4_ack_legal", acks, 4'b0001); sb.push_back({2'd0, 8'h11});
    cyc(); set_gnt(4'b0000); vld0 = 0;
    @(negedge clk);
    chk("t4_err_sticky", gnt_err, 1);
    chk("t4_out_data", out_data, 8'h11);

    // 5: async reset while a beat is held
    cyc(); set_gnt(4'b0100); vld2 = 1; data2 = 8'h5A; out_rdy = 0;
    @(negedge clk);
    chk("t5_ack", acks, 4'b0100);
    cyc(); vld2 = 0;
    @(negedge clk);
    chk("t5_held", out_vld, 1);
    #2 rst = 0;
    #1;
    chk("t5_async_vld", out_vld, 0);
    chk("t5_async_data", out_data, 0);
    chk("t5_async_err", gnt_err, 0);
    chk("t5_async_exp", tenure_exp, 0);
    chk("t5_async_cnt", beat_cnt, 0);
    sb.delete();
    cyc(); set_gnt(4'b0000); out_rdy = 1;
    #2 rst = 1;

    // 6: continuous stream, grant alternating every 4 beats
    n_ack = 0;
    for (int i = 0; i < n_beats; i++) begin
      cyc();
      set_gnt(((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
      vld0 = 1; vld1 = 1; data0 = 8'(i); data1 = 8'(i);
      sb.push_back({((i / 4) % 2 == 0) ? 2'd0 : 2'd1, 8'(i)});
      @(negedge clk);
      if (ack0 || ack1) n_ack++;
    end
    chk("t6_ack_count", n_ack, n_beats);
    cyc(); set_gnt(4'b0000); vld0 = 0; vld1 = 0;
    cyc();
    @(negedge clk);
    chk("t6_beat_cnt", beat_cnt, exp_cnt);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/arb_grant_mux.md
Name: arb_grant_mux

Overview:
- Downstream consumer of the 4-way arbiter grants (gnt3..gnt0).
- Steers the granted requester's data beat onto a single registered output channel with valid/ready handshake.
- Returns a per-requester accept pulse (ackN) to each source.
- Enforces a maximum beats-per-grant tenure and flags illegal (multi-hot) grant vectors.

Parameters:
- DW, 8, data width of each source and of the output
- MAX_TENURE, 4, maximum beats accepted per continuous grant; range 1..15

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-low reset (rst=0 resets)
- gnt3, gnt2, gnt1, gnt0  in  1 each  grants from arbiter; expected one-hot or zero
- vld3, vld2, vld1, vld0  in  1 each  source N has a beat on dataN
- data3, data2, data1, data0  in  DW each  source beat data
- ack3, ack2, ack1, ack0  out  1 each  combinational pulse: source N's beat accepted this cycle
- out_data  out  DW  registered output beat
- out_src  out  2  index of source that produced out_data
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream ready
- tenure_exp  out  1  current grant has used MAX_TENURE beats
- gnt_err  out  1  sticky: multi-hot grant observed
- beat_cnt  out  16  total accepted beats (see Optional Feature)

Behaviour:
- Reset (async, rst=0): out_vld=0, out_data=0, out_src=0, tenure count=0, prev-grant register=0, gnt_err=0, beat_cnt=0. Acks are 0 while in reset. Reset mid-transfer drops the held beat; no ack is re-issued.
- Grant decode (combinational):
  - One-hot: sel = index, active=1.
  - All-zero: active=0.
  - Multi-hot: active=0; gnt_err set on next edge, held until reset.
- Load condition: load = active & vld[sel] & (!out_vld | out_rdy) & !tenure_exp.
- On load:
  - ack[sel]=1 in the same cycle; all other acks 0.
  - Next edge: out_data<=data[sel], out_src<=sel, out_vld<=1.
- Without load: if out_rdy=1 then out_vld<=0; otherwise out_data, out_src and out_vld hold.
- Latency: source beat to out_vld is 1 cycle. Full throughput is one beat per cycle with out_rdy held high.
- Tenure counter (4 bits):
  - Clears to 0 when the grant vector differs from the previous cycle's vector, or when the grant is zero or multi-hot.
  - Otherwise increments on load, saturating at MAX_TENURE.
  - tenure_exp = (count == MAX_TENURE) is combinational from the register and blocks further loads until the grant changes.
- Same grant re-asserted after a 1-cycle gap: counter restarts from 0.
- Grant switching while out_vld=1 and out_rdy=0: the held beat is kept unchanged with its old out_src. The new source cannot load until the output slot frees.
- Simultaneous free and load (out_vld=1, out_rdy=1, load=1): the output is replaced by the new beat with no bubble.
- vld for a non-granted source is ignored; its ack stays 0.

Optional Feature:
- Macro: ARB_GRANT_MUX_STATS_EN.
- Defined: beat_cnt increments by 1 on every load and wraps 0xFFFF -> 0x0000. Reset value is 0.
- Undefined: beat_cnt is tied to 0 and no counter flops are instantiated. The port list is identical in both builds.

Test Plan:
1. Reset, then gnt0=1, vld0=1, data0=0xA5, out_rdy=1 -> ack0=1 that cycle; next cycle out_vld=1, out_data=0xA5, out_src=0.
2. Backpressure: gnt2=1, vld2=1, data2=0x3C, out_rdy=0 -> one ack2, then out_data=0x3C held and ack2=0 until out_rdy=1. Raising out_rdy with the next beat 0x3D gives out_data=0x3D one cycle later with no bubble.
3. Tenure: gnt1 held 6 cycles, vld1=1, out_rdy=1 -> exactly 4 ack1 pulses; tenure_exp=1 from cycle 5. Switching to gnt3 clears tenure_exp, and ack3 is asserted the same cycle.
4. Illegal grant: gnt=0011 with vld0=vld1=1 -> no ack, out_vld stays 0; gnt_err=1 next cycle and stays 1 after the grant returns to 0001, until rst=0.
5. Async reset mid-stream: out_vld=1 with out_rdy=0, then assert rst=0 between edges -> out_vld, out_data, gnt_err and tenure count go to 0 immediately, without waiting for a clock edge.
6. With ARB_GRANT_MUX_STATS_EN: 70000 accepted beats -> beat_cnt=4464 (wrapped). Without the macro, beat_cnt=0 throughout.
